// File: rtl/tick_rst_gen_if.sv
// Control/status bundle for tick_rst_gen: count enable and divisors in,
// per-channel ticks, phases, resets and the global ready flag out.
interface tick_rst_gen_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 8
);
  logic                    en;
  logic [NUM_CH*DIV_W-1:0] div;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       phase;
  logic [NUM_CH-1:0]       rst_out;
  logic                    ready;

  modport master (
    output en, div,
    input  tick, phase, rst_out, ready
  );

  modport slave (
    input  en, div,
    output tick, phase, rst_out, ready
  );
endinterface

// File: rtl/tick_rst_gen.sv
// Single-clock tick/phase generator with a staggered per-channel reset release.
// Optional TICK_GEN_SOFT_RST_EN adds a soft_rst input that replays the sequence.
module tick_rst_gen #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned RST_HOLD   = 16,
  parameter int unsigned CH_STAGGER = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef TICK_GEN_SOFT_RST_EN
  input  logic soft_rst,
`endif
  tick_rst_gen_if.slave bus
);

  localparam int unsigned LastThr = RST_HOLD + (NUM_CH - 1) * CH_STAGGER;
  localparam int unsigned CntW    = $clog2(LastThr + 1);

  typedef enum logic [1:0] {StHold, StStagger, StRun} state_e;

  state_e            state_q;
  logic [CntW-1:0]   seq_q;
  logic [NUM_CH-1:0] rst_out_q;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] phase_q;
  logic              ready_q;
  logic [DIV_W-1:0]  dcnt_q  [NUM_CH];
  logic [DIV_W-1:0]  shd_q   [NUM_CH];
  logic [DIV_W-1:0]  div_eff [NUM_CH];
  logic [NUM_CH-1:0] rel;
  logic              restart;

`ifdef TICK_GEN_SOFT_RST_EN
  assign restart = rst | soft_rst;
`else
  assign restart = rst;
`endif

  // rel[i] marks the edge at which channel i leaves reset.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      div_eff[i] = bus.div[i*DIV_W +: DIV_W];
      if (div_eff[i] == '0) div_eff[i] = DIV_W'(1);
      rel[i] = rst_out_q[i] && (seq_q >= CntW'(RST_HOLD + i * CH_STAGGER));
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q   <= StHold;
      seq_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      tick_q    <= '0;
      phase_q   <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        dcnt_q[i] <= '0;
        // Soft restart keeps the shadows; they are re-latched at release anyway.
        if (rst) shd_q[i] <= DIV_W'(1);
      end
    end else begin
      unique case (state_q)
        StHold: begin
          seq_q <= seq_q + CntW'(1);
          if (seq_q == CntW'(RST_HOLD - 1)) state_q <= StStagger;
        end
        StStagger: begin
          if (seq_q == CntW'(LastThr)) state_q <= StRun;
          else                         seq_q   <= seq_q + CntW'(1);
        end
        StRun:   seq_q   <= seq_q;
        default: state_q <= StHold;
      endcase
      ready_q <= (state_q == StRun);

      for (int i = 0; i < int'(NUM_CH); i++) begin
        rst_out_q[i] <= rst_out_q[i] & ~rel[i];
        if (rst_out_q[i]) begin
          dcnt_q[i] <= '0;
          tick_q[i] <= 1'b0;
          if (rel[i]) shd_q[i] <= div_eff[i];
        end else if (!bus.en) begin
          tick_q[i] <= 1'b0;
        end else if (dcnt_q[i] == shd_q[i] - DIV_W'(1)) begin
          dcnt_q[i]  <= '0;
          tick_q[i]  <= 1'b1;
          phase_q[i] <= ~phase_q[i];
          shd_q[i]   <= div_eff[i];
        end else begin
          dcnt_q[i] <= dcnt_q[i] + DIV_W'(1);
          tick_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.tick    = tick_q;
  assign bus.phase   = phase_q;
  assign bus.rst_out = rst_out_q;
  assign bus.ready   = ready_q;

endmodule

// File: tb/tb_tick_rst_gen.sv
// Bench for tick_rst_gen: timeline reference model checked every cycle, a vector
// table of tick-rate windows, hand sequences for corner cases, then random traffic.
module tb_tick_rst_gen;
  localparam int NCH     = 4;
  localparam int DW      = 8;
  localparam int HOLD    = 16;
  localparam int STG     = 4;
  localparam int LASTTHR = HOLD + (NCH - 1) * STG;

  logic             clk = 1'b0;
  logic             rst_v = 1'b1;
  logic             soft_v = 1'b0;
  logic             en_v = 1'b1;
  logic [NCH*DW-1:0] div_v = '0;

  int n_cmp = 0;
  int n_err = 0;

  tick_rst_gen_if #(.NUM_CH(NCH), .DIV_W(DW)) bus ();
  assign bus.en  = en_v;
  assign bus.div = div_v;

  tick_rst_gen #(
    .NUM_CH    (NCH),
    .DIV_W     (DW),
    .RST_HOLD  (HOLD),
    .CH_STAGGER(STG)
  ) dut (
    .clk     (clk),
`ifdef TICK_GEN_SOFT_RST_EN
    .soft_rst(soft_v),
`endif
    .rst     (rst_v),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: position on the release timeline plus absolute tick targets.
  int          m_idx = -1;
  int          ecnt [NCH];
  int          due  [NCH];
  logic [NCH-1:0] e_tick = '0, e_phase = '0, e_rst_out = '1;
  logic        e_ready = 1'b0;

  function automatic int dsel(int i);
    logic [DW-1:0] d;
    d = div_v[i*DW +: DW];
    return (d == '0) ? 1 : int'(d);
  endfunction

  function automatic logic [NCH*DW-1:0] pack(int d3, int d2, int d1, int d0);
    return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
  endfunction

  task automatic model_step();
    if (rst_v || soft_v) begin
      m_idx = -1; e_tick = '0; e_phase = '0; e_rst_out = '1; e_ready = 1'b0;
    end else begin
      m_idx++;
      for (int i = 0; i < NCH; i++) begin
        int thr;
        thr = HOLD + i * STG;
        e_tick[i] = 1'b0;
        if (m_idx == thr) begin
          ecnt[i] = 0;
          due[i]  = dsel(i);
        end else if (m_idx > thr && en_v) begin
          ecnt[i]++;
          if (ecnt[i] == due[i]) begin
            e_tick[i]  = 1'b1;
            e_phase[i] = ~e_phase[i];
            due[i]     = due[i] + dsel(i);
          end
        end
        e_rst_out[i] = !(m_idx >= thr);
      end
      e_ready = (m_idx >= LASTTHR + 1);
    end
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("cycle {ready,rst_out,phase,tick}",
          64'({bus.ready, bus.rst_out, bus.phase, bus.tick}),
          64'({e_ready, e_rst_out, e_phase, e_tick}));
  endtask

  task automatic do_reset(int n);
    rst_v = 1'b1;
    repeat (n) cyc();
    rst_v = 1'b0;
  endtask

  // Starts at E0; measures release and ready edges relative to it.
  task automatic seq_check(string tag);
    int fall [NCH];
    int rdy;
    rdy = -1;
    for (int i = 0; i < NCH; i++) fall[i] = -1;
    for (int m = 0; m <= LASTTHR + 8; m++) begin
      cyc();
      for (int i = 0; i < NCH; i++) if (fall[i] < 0 && !bus.rst_out[i]) fall[i] = m;
      if (rdy < 0 && bus.ready) rdy = m;
    end
    for (int i = 0; i < NCH; i++)
      check($sformatf("%s rst_out[%0d] release edge", tag, i), 64'(fall[i]), 64'(HOLD + i * STG));
    check({tag, " ready edge"}, 64'(rdy), 64'(LASTTHR + 1));
  endtask

  task automatic run_to_ready();
    for (int k = 0; k < 100 && m_idx != LASTTHR + 1; k++) cyc();
    check("reached ready point", 64'(m_idx), 64'(LASTTHR + 1));
  endtask

  typedef struct {
    logic [NCH*DW-1:0] div;
    int                n;
    logic [NCH-1:0][7:0] exp_cnt;
  } vec_t;

  vec_t vecs [3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int cnt [NCH];
    int pos [3];
    int np, en_edges, quiet, found;

    vecs[0] = '{div: pack(8, 4, 2, 1), n: 80, exp_cnt: {8'd10, 8'd20, 8'd40, 8'd80}};
    vecs[1] = '{div: pack(0, 0, 0, 0), n: 80, exp_cnt: {8'd80, 8'd80, 8'd80, 8'd80}};
    vecs[2] = '{div: pack(3, 5, 6, 7), n: 80, exp_cnt: {8'd26, 8'd16, 8'd13, 8'd12}};

    // Reset values and the release sequence.
    div_v = pack(8, 4, 2, 1);
    do_reset(3);
    check("reset rst_out", 64'(bus.rst_out), 64'(4'hf));
    check("reset tick",    64'(bus.tick),    64'(0));
    check("reset phase",   64'(bus.phase),   64'(0));
    check("reset ready",   64'(bus.ready),   64'(0));
    seq_check("initial");

    // Rate table: tick counts over a window starting at the ready edge.
    for (int v = 0; v < 3; v++) begin
      div_v = vecs[v].div;
      en_v  = 1'b1;
      do_reset(2);
      run_to_ready();
      for (int i = 0; i < NCH; i++) cnt[i] = 0;
      for (int k = 0; k < vecs[v].n; k++) begin
        if (k > 0) cyc();
        for (int i = 0; i < NCH; i++) cnt[i] += int'(bus.tick[i]);
      end
      for (int i = 0; i < NCH; i++)
        check($sformatf("vec%0d ch%0d tick count", v, i), 64'(cnt[i]), 64'(vecs[v].exp_cnt[i]));
    end

    // Divisor 0 then 5 on ch1: the pending 1-cycle period completes, then spacing 5.
    div_v = pack(8, 4, 0, 1);
    do_reset(2);
    run_to_ready();
    div_v = pack(8, 4, 5, 1);
    np = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (bus.tick[1] && np < 3) begin pos[np] = k; np++; end
    end
    check("div change tick count", 64'(np), 64'(3));
    check("div change first tick", 64'(pos[0]), 64'(1));
    check("div change 2nd tick",   64'(pos[1]), 64'(6));
    check("div change 3rd tick",   64'(pos[2]), 64'(11));

    // Enable gating on ch3 (d=8): 3 enabled, 7 disabled, then resume.
    div_v = pack(8, 4, 2, 1);
    do_reset(2);
    run_to_ready();
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cyc();
      if (bus.tick[3]) found = 1;
    end
    check("gating first ch3 tick seen", 64'(found), 64'(1));
    en_edges = 0;
    repeat (3) begin cyc(); en_edges++; end
    en_v = 1'b0;
    quiet = 0;
    repeat (7) begin cyc(); quiet += int'(bus.tick != '0); end
    en_v = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cyc();
      en_edges++;
      if (bus.tick[3]) found = 1;
    end
    check("gating ticks while en low", 64'(quiet), 64'(0));
    check("gating resumed ch3 tick", 64'(found), 64'(1));
    check("gating enabled edges between ticks", 64'(en_edges), 64'(8));

    // Reset pulse at E0+22, then the full replay.
    div_v = pack(2, 3, 1, 1);
    do_reset(3);
    repeat (22) cyc();
    rst_v = 1'b1;
    cyc();
    check("mid rst rst_out", 64'(bus.rst_out), 64'(4'hf));
    check("mid rst tick",    64'(bus.tick),    64'(0));
    check("mid rst phase",   64'(bus.phase),   64'(0));
    check("mid rst ready",   64'(bus.ready),   64'(0));
    rst_v = 1'b0;
    seq_check("replay");

`ifdef TICK_GEN_SOFT_RST_EN
    soft_v = 1'b1;
    cyc();
    soft_v = 1'b0;
    check("soft rst rst_out", 64'(bus.rst_out), 64'(4'hf));
    check("soft rst ready",   64'(bus.ready),   64'(0));
    seq_check("soft replay");
    rst_v = 1'b1; soft_v = 1'b1;
    cyc();
    rst_v = 1'b0; soft_v = 1'b0;
    seq_check("rst+soft replay");
`endif

    // Random traffic against the model.
    div_v = pack(3, 0, 5, 2);
    do_reset(2);
    for (int k = 0; k < 3000; k++) begin
      en_v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0)
        div_v = pack($urandom_range(0, 12), $urandom_range(0, 12),
                     $urandom_range(0, 12), $urandom_range(0, 12));
      rst_v = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst_v = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
